l1d_mem_if: RTL

Memory-side interface stage directly downstream of the L1 data cache. It accepts one line-refill or write-through store request at a time from the L1D controller and issues it as a single transaction on the memory bus. For refills it assembles the returned beats into a full cache line and delivers that line to the L1D in one cycle. For stores it signals completion back to the L1D.

---
 rtl/l1d_pkg.sv | 21 ++
 rtl/l1d_mem_if.sv | 123 ++++++++++++
 2 files changed

// File: rtl/l1d_pkg.sv
// Shared definitions for the L1 data cache and its memory-bus interface stage.
// Holds the request opcode encodings, the interface FSM states and default widths.
package l1d_pkg;

  localparam int L1D_ADDR_WIDTH = 32;
  localparam int L1D_DATA_WIDTH = 32;
  localparam int L1D_LINE_WIDTH = 128;

  localparam logic L1D_MEM_RD_LINE = 1'b0;
  localparam logic L1D_MEM_WR      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_FILL    = 3'd3,
    ST_WR_REQ  = 3'd4,
    ST_WR_WAIT = 3'd5
  } l1d_mem_state_t;

endpackage

// File: rtl/l1d_mem_if.sv
// Memory-side stage below the L1D: issues one refill or write-through store at a
// time on the memory bus, assembles refill beats into a line and reports completion.
module l1d_mem_if
  import l1d_pkg::*;
#(
  parameter int ADDR_WIDTH = L1D_ADDR_WIDTH,
  parameter int DATA_WIDTH = L1D_DATA_WIDTH,
  parameter int LINE_WIDTH = L1D_LINE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      l1d_req_val,
  output logic                      l1d_req_rdy,
  input  logic                      l1d_req_cop,
  input  logic [ADDR_WIDTH-1:0]     l1d_req_addr,
  input  logic [DATA_WIDTH-1:0]     l1d_req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   l1d_req_be,
  output logic                      l1d_fill_val,
  output logic [ADDR_WIDTH-1:0]     l1d_fill_addr,
  output logic [LINE_WIDTH-1:0]     l1d_fill_data,
  output logic                      l1d_wr_done,
  output logic                      l1d_err,
  output logic                      mem_req_val,
  input  logic                      mem_req_ack,
  output logic                      mem_req_cop,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  output logic [DATA_WIDTH-1:0]     mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_req_be,
  input  logic                      mem_resp_val,
  input  logic [DATA_WIDTH-1:0]     mem_resp_data
);

  localparam int BEATS  = LINE_WIDTH / DATA_WIDTH;
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

  l1d_mem_state_t              state, state_nxt;
  logic [BEAT_W-1:0]           beat_cnt;
  logic                        cop_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [DATA_WIDTH-1:0]       wdata_q;
  logic [DATA_WIDTH/8-1:0]     be_q;
  logic                        wr_done_q;
  logic                        err_q;
  logic [DATA_WIDTH-1:0]       line_buf [BEATS];

  logic accept;
  logic last_beat;
  logic resp_unexpected;

  assign accept          = l1d_req_val && (state == ST_IDLE);
  assign last_beat       = (beat_cnt == BEAT_W'(BEATS - 1));
  // Responses are only legal while collecting beats or waiting for a store ack.
  assign resp_unexpected = mem_resp_val && (state != ST_RD_DATA) && (state != ST_WR_WAIT);

  // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = (l1d_req_cop == L1D_MEM_WR) ? ST_WR_REQ : ST_RD_REQ;
      ST_RD_REQ:  if (mem_req_ack) state_nxt = ST_RD_DATA;
      ST_RD_DATA: if (mem_resp_val && last_beat) state_nxt = ST_FILL;
      ST_FILL:    state_nxt = ST_IDLE;
      ST_WR_REQ:  if (mem_req_ack) state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: if (mem_resp_val) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      cop_q     <= L1D_MEM_RD_LINE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_done_q <= (state == ST_WR_WAIT) && mem_resp_val;
      err_q     <= resp_unexpected;
      if (accept) begin
        cop_q    <= l1d_req_cop;
        addr_q   <= l1d_req_addr & ((l1d_req_cop == L1D_MEM_WR) ? WORD_MASK : LINE_MASK);
        wdata_q  <= l1d_req_wdata;
        be_q     <= l1d_req_be;
        beat_cnt <= '0;
      end else if ((state == ST_RD_DATA) && mem_resp_val) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end

  // NOTE: the line buffer is reset because it drives l1d_fill_data directly and must read zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BEATS; i++) line_buf[i] <= '0;
    end else if ((state == ST_RD_DATA) && mem_resp_val) begin
      line_buf[beat_cnt] <= mem_resp_data;
    end
  end

  always_comb begin
    l1d_fill_data = '0;
    for (int i = 0; i < BEATS; i++) l1d_fill_data[i*DATA_WIDTH +: DATA_WIDTH] = line_buf[i];
  end

  assign l1d_req_rdy   = (state == ST_IDLE);
  assign mem_req_val   = (state == ST_RD_REQ) || (state == ST_WR_REQ);
  assign l1d_fill_val  = (state == ST_FILL);
  assign l1d_fill_addr = addr_q;
  assign l1d_wr_done   = wr_done_q;
  assign l1d_err       = err_q;
  assign mem_req_cop   = cop_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_be    = be_q;

endmodule
